// File: rtl/axonerve_kvs_stream_arbiter.sv
// axonerve_kvs_stream_arbiter
//   Packet-level round-robin arbiter that shares one constant-adder stream
//   datapath between two AXI4-Stream requesters. The arbiter grants a whole
//   packet (through tlast) to one input and latches that input's constant onto
//   adder_constant. Beats reach the adder through a single output register
//   stage.
//   Optional feature: define ARB_PKT_COUNT_EN to add the per-input packet
//   counters pkt_cnt0/pkt_cnt1. Without it, those ports and counters do not
//   exist.
module axonerve_kvs_stream_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant0,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant1,
  input  logic                            s0_axis_tvalid,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                            s0_axis_tlast,
  input  logic                            s1_axis_tvalid,
  output logic                            s1_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                            s1_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_ADDER_BIT_WIDTH-1:0]    adder_constant,
  output logic                            grant_valid,
  output logic                            grant_id
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt1
`endif
);

  localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    rr_ptr_r;
  logic                    winner_r;
  logic                    pick_s;
  logic                    start_s;
  logic                    done_s;
  logic                    accept_ready_s;
  logic                    beat_hs_s;
  logic                    sel_tvalid_s;
  logic                    sel_tlast_s;
  logic [C_AXIS_TDATA_WIDTH-1:0] sel_tdata_s;
  logic [KEEP_W-1:0]       sel_tkeep_s;

  // Steer the granted input's beat toward the output register.
  always_comb begin
    sel_tvalid_s = 1'b0;
    sel_tlast_s  = 1'b0;
    sel_tdata_s  = {C_AXIS_TDATA_WIDTH{1'b0}};
    sel_tkeep_s  = {KEEP_W{1'b0}};
    if (winner_r) begin
      sel_tvalid_s = s1_axis_tvalid;
      sel_tlast_s  = s1_axis_tlast;
      sel_tdata_s  = s1_axis_tdata;
      sel_tkeep_s  = s1_axis_tkeep;
    end else begin
      sel_tvalid_s = s0_axis_tvalid;
      sel_tlast_s  = s0_axis_tlast;
      sel_tdata_s  = s0_axis_tdata;
      sel_tkeep_s  = s0_axis_tkeep;
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign accept_ready_s = ~m_axis_tvalid | m_axis_tready;
  assign beat_hs_s      = (state_r == ST_XFER) & sel_tvalid_s & accept_ready_s;

  // Next-state, arbitration decision and per-input ready.
  always_comb begin
    state_next_s   = state_r;
    pick_s         = 1'b0;
    start_s        = 1'b0;
    done_s         = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Wait for an empty output register so the constant never changes
        // under a beat still sitting at the adder.
        if ((s0_axis_tvalid | s1_axis_tvalid) & ~m_axis_tvalid) begin
          start_s      = 1'b1;
          state_next_s = ST_SETUP;
          if (s0_axis_tvalid & s1_axis_tvalid) begin
            pick_s = rr_ptr_r;
          end else begin
            pick_s = s1_axis_tvalid;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_XFER;
      end
      ST_XFER: begin
        if (winner_r) begin
          s1_axis_tready = accept_ready_s;
        end else begin
          s0_axis_tready = accept_ready_s;
        end
        if (beat_hs_s & sel_tlast_s) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_XFER;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched winner and round-robin pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r  <= ST_IDLE;
      winner_r <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        winner_r <= pick_s;
      end
      if (done_s) begin
        rr_ptr_r <= ~winner_r;
      end
    end
  end

  // Grant status and the adder constant, which is only captured in SETUP.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      adder_constant <= {C_ADDER_BIT_WIDTH{1'b0}};
      grant_id       <= 1'b0;
      grant_valid    <= 1'b0;
    end else begin
      if (state_r == ST_SETUP) begin
        adder_constant <= winner_r ? ctrl_constant1 : ctrl_constant0;
        grant_id       <= winner_r;
      end
      if (start_s) begin
        grant_valid <= 1'b1;
      end else if (done_s) begin
        grant_valid <= 1'b0;
      end
    end
  end

  // Output register stage; payload holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {C_AXIS_TDATA_WIDTH{1'b0}};
      m_axis_tkeep  <= {KEEP_W{1'b0}};
      m_axis_tlast  <= 1'b0;
    end else if (beat_hs_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_tdata_s;
      m_axis_tkeep  <= sel_tkeep_s;
      m_axis_tlast  <= sel_tlast_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef ARB_PKT_COUNT_EN
  // Count completed packets per input; wraps at the counter width.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0 <= {C_CNT_WIDTH{1'b0}};
      pkt_cnt1 <= {C_CNT_WIDTH{1'b0}};
    end else if (done_s) begin
      if (winner_r) begin
        pkt_cnt1 <= pkt_cnt1 + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt0 <= pkt_cnt0 + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_axonerve_kvs_stream_arbiter.sv
// tb_axonerve_kvs_stream_arbiter
//   Randomized packet traffic against a packet-level reference model: the
//   model builds the expected output order from round-robin rules, and each
//   packet's constant is the input's constant when the packet starts.
module tb_axonerve_kvs_stream_arbiter;
  localparam int W   = 512;
  localparam int KW  = 64;
  localparam int CAB = 32;
  localparam int CW  = 16;

  typedef struct {
    logic          src;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    int            pkt;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CAB-1:0] ctrl_constant0 = 32'd0;
  logic [CAB-1:0] ctrl_constant1 = 32'd0;
  logic          s0_axis_tvalid = 1'b0, s0_axis_tready;
  logic [W-1:0]  s0_axis_tdata = '0;
  logic [KW-1:0] s0_axis_tkeep = '0;
  logic          s0_axis_tlast = 1'b0;
  logic          s1_axis_tvalid = 1'b0, s1_axis_tready;
  logic [W-1:0]  s1_axis_tdata = '0;
  logic [KW-1:0] s1_axis_tkeep = '0;
  logic          s1_axis_tlast = 1'b0;
  logic          m_axis_tvalid, m_axis_tready = 1'b0;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [CAB-1:0] adder_constant;
  logic          grant_valid, grant_id;
`ifdef ARB_PKT_COUNT_EN
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit    model_ptr = 1'b0;
  int    model_cnt0 = 0, model_cnt1 = 0;
  beat_t src_q0[$], src_q1[$], exp_q[$];
  logic [CAB-1:0] pkt_const[$];
  int    idx0, idx1, gap_pct, stall_pct;
  bit    s0_en;

  axonerve_kvs_stream_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctrl_constant0(ctrl_constant0), .ctrl_constant1(ctrl_constant1),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .adder_constant(adder_constant), .grant_valid(grant_valid), .grant_id(grant_id)
`ifdef ARB_PKT_COUNT_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit outputs_zero();
    bit z;
    z = (m_axis_tvalid === 1'b0) && (m_axis_tdata === '0) && (m_axis_tkeep === '0) &&
        (m_axis_tlast === 1'b0) && (s0_axis_tready === 1'b0) && (s1_axis_tready === 1'b0) &&
        (adder_constant === '0) && (grant_valid === 1'b0) && (grant_id === 1'b0);
`ifdef ARB_PKT_COUNT_EN
    z = z && (pkt_cnt0 === '0) && (pkt_cnt1 === '0);
`endif
    return z;
  endfunction

  task automatic reset_dut();
    aresetn = 1'b0;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_ptr = 1'b0; model_cnt0 = 0; model_cnt1 = 0;
  endtask

  // Advance the source cursors after handshakes and present the next beats.
  task automatic drive_inputs(input bit hs0, input bit hs1);
    bit v;
    if (hs0) idx0++;
    if (hs1) begin idx1++; s0_en = 1'b1; end
    if (idx0 < src_q0.size() && s0_en) begin
      if (s0_axis_tvalid && !hs0) v = 1'b1;
      else if (idx0 == 0 || src_q0[idx0-1].last) v = 1'b1;
      else v = ($urandom_range(99) >= gap_pct);
      s0_axis_tvalid = v; s0_axis_tdata = src_q0[idx0].data;
      s0_axis_tkeep = src_q0[idx0].keep; s0_axis_tlast = src_q0[idx0].last;
    end else begin
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    end
    if (idx1 < src_q1.size()) begin
      if (s1_axis_tvalid && !hs1) v = 1'b1;
      else if (idx1 == 0 || src_q1[idx1-1].last) v = 1'b1;
      else v = ($urandom_range(99) >= gap_pct);
      s1_axis_tvalid = v; s1_axis_tdata = src_q1[idx1].data;
      s1_axis_tkeep = src_q1[idx1].keep; s1_axis_tlast = src_q1[idx1].last;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    end
    m_axis_tready = ($urandom_range(99) >= stall_pct);
  endtask

  // Generate n0/n1 packets, build the expected order, run and score the traffic.
  task automatic run_traffic(input int n0, input int n1, input int minlen, input int maxlen,
                             input int gap, input int stall, input int chg, input bit s0_late);
    int len0[$], len1[$];
    int c0, c1, b0, b1, pk, in_idx, out_idx, cyc;
    bit p, x, first, hs0, hs1, prev_hs, got_src;
    beat_t bt, e, prev_beat;
    logic [W-1:0] gd;
    src_q0.delete(); src_q1.delete(); exp_q.delete(); pkt_const.delete();
    gap_pct = gap; stall_pct = stall;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < (k == 0 ? n0 : n1); n++) begin
        int len = $urandom_range(maxlen, minlen);
        if (k == 0) len0.push_back(len); else len1.push_back(len);
        for (int i = 0; i < len; i++) begin
          bt.src = k[0]; bt.data = rand_data(); bt.keep = {$urandom, $urandom};
          bt.last = (i == len - 1); bt.pkt = 0;
          if (k == 0) src_q0.push_back(bt); else src_q1.push_back(bt);
        end
      end
    end
    // Expected order: alternate from the pointer while both have packets; a
    // lone requester wins regardless; the pointer moves past each winner.
    c0 = 0; c1 = 0; b0 = 0; b1 = 0; pk = 0; p = model_ptr; first = 1'b1;
    while (c0 < n0 || c1 < n1) begin
      if (first && s0_late && c1 < n1) x = 1'b1;
      else if (c0 < n0 && c1 < n1) x = p;
      else if (c0 < n0) x = 1'b0;
      else x = 1'b1;
      first = 1'b0;
      if (!x) begin
        for (int i = 0; i < len0[c0]; i++) begin bt = src_q0[b0]; bt.pkt = pk; exp_q.push_back(bt); b0++; end
        c0++; model_cnt0++;
      end else begin
        for (int i = 0; i < len1[c1]; i++) begin bt = src_q1[b1]; bt.pkt = pk; exp_q.push_back(bt); b1++; end
        c1++; model_cnt1++;
      end
      pkt_const.push_back(32'd0);
      pk++; p = ~x;
    end
    model_ptr = p;

    idx0 = 0; idx1 = 0; s0_en = !s0_late || (n1 == 0);
    in_idx = 0; out_idx = 0; cyc = 0; prev_hs = 1'b0;
    drive_inputs(1'b0, 1'b0);
    while (out_idx < exp_q.size() && cyc < 4000) begin
      @(negedge aclk);
      if (prev_hs) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_beat.data || m_axis_tlast !== prev_beat.last) begin
          errors++;
          $display("FAIL latency: m_tvalid=%0b m_tlast=%0b, required 1/%0b with accepted data", m_axis_tvalid, m_axis_tlast, prev_beat.last);
        end
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++;
        if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: s0_tready=%0b s1_tready=%0b, required 0/0", s0_axis_tready, s1_axis_tready);
        end
      end
      checks++;
      if (in_idx < exp_q.size()) begin
        if ((exp_q[in_idx].src ? s0_axis_tready : s1_axis_tready) !== 1'b0) begin
          errors++;
          $display("FAIL loser_ready: non-granted input %0d has tready=1, required 0", !exp_q[in_idx].src);
        end
      end else if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready: s0_tready=%0b s1_tready=%0b, required 0/0", s0_axis_tready, s1_axis_tready);
      end
      hs0 = s0_axis_tvalid && s0_axis_tready;
      hs1 = s1_axis_tvalid && s1_axis_tready;
      if (hs0 || hs1) begin
        got_src = hs1;
        checks++;
        if (in_idx >= exp_q.size()) begin
          errors++;
          $display("FAIL input_extra: handshake on input %0d, required none", got_src);
        end else begin
          e = exp_q[in_idx];
          gd = got_src ? s1_axis_tdata : s0_axis_tdata;
          if ((hs0 && hs1) || got_src !== e.src || gd !== e.data) begin
            errors++;
            $display("FAIL input_order: beat %0d taken from input %0d (both=%0b), required input %0d", in_idx, got_src, hs0 && hs1, e.src);
          end
          if (in_idx == 0 || exp_q[in_idx-1].pkt != e.pkt) begin
            pkt_const[e.pkt] = e.src ? ctrl_constant1 : ctrl_constant0;
            checks++;
            if (adder_constant !== pkt_const[e.pkt] || grant_id !== e.src || grant_valid !== 1'b1) begin
              errors++;
              $display("FAIL setup: const=%0h grant_id=%0b grant_valid=%0b, required %0h/%0b/1", adder_constant, grant_id, grant_valid, pkt_const[e.pkt], e.src);
            end
          end
          prev_beat = e;
          in_idx++;
        end
      end
      prev_hs = hs0 || hs1;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (out_idx >= exp_q.size()) begin
          errors++;
          $display("FAIL out_extra: unexpected output beat, required none");
        end else begin
          e = exp_q[out_idx];
          if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last ||
              adder_constant !== pkt_const[e.pkt] || grant_id !== e.src) begin
            errors++;
            $display("FAIL out_beat %0d: data=%h keep=%h last=%0b const=%0h id=%0b, required data=%h keep=%h last=%0b const=%0h id=%0b",
                     out_idx, m_axis_tdata, m_axis_tkeep, m_axis_tlast, adder_constant, grant_id,
                     e.data, e.keep, e.last, pkt_const[e.pkt], e.src);
          end
          out_idx++;
        end
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (in_idx > 0 && in_idx < exp_q.size() && exp_q[in_idx].pkt == exp_q[in_idx-1].pkt &&
          $urandom_range(99) < chg) begin
        ctrl_constant0 = $urandom;
        ctrl_constant1 = $urandom;
      end
      drive_inputs(hs0, hs1);
    end
    checks++;
    if (out_idx != exp_q.size()) begin
      errors++;
      $display("FAIL timeout: %0d output beats seen, required %0d", out_idx, exp_q.size());
    end
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: m_tvalid=%0b grant_valid=%0b, required 0/0", m_axis_tvalid, grant_valid);
    end
`ifdef ARB_PKT_COUNT_EN
    checks++;
    if (pkt_cnt0 !== CW'(model_cnt0) || pkt_cnt1 !== CW'(model_cnt1)) begin
      errors++;
      $display("FAIL pkt_cnt: got %0d/%0d, required %0d/%0d", pkt_cnt0, pkt_cnt1, CW'(model_cnt0), CW'(model_cnt1));
    end
`endif
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL reset_hold: m_tvalid=%0b tready=%0b%0b const=%0h gv=%0b gid=%0b, required all 0",
               m_axis_tvalid, s0_axis_tready, s1_axis_tready, adder_constant, grant_valid, grant_id);
    end
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    reset_dut();
    @(negedge aclk);
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL reset_release: outputs not idle after release, required all 0");
    end
  endtask

  task automatic test_single_packet();
    ctrl_constant0 = 32'd5; ctrl_constant1 = 32'd11;
    run_traffic(1, 0, 4, 4, 0, 0, 0, 1'b0);
    checks++;
    if (adder_constant !== 32'd5 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL single_pkt: const=%0h grant_id=%0b, required 5/0", adder_constant, grant_id);
    end
  endtask

  task automatic test_round_robin();
    ctrl_constant0 = 32'h0000_1000; ctrl_constant1 = 32'h0000_2000;
    run_traffic(4, 4, 3, 3, 0, 0, 0, 1'b0);
  endtask

  task automatic test_s1_first();
    reset_dut();
    run_traffic(2, 2, 4, 4, 0, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_traffic(3, 3, 1, 6, 30, 50, 0, 1'b0);
  endtask

  task automatic test_const_change();
    ctrl_constant0 = 32'd5; ctrl_constant1 = 32'd7;
    run_traffic(3, 1, 4, 6, 10, 20, 40, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    ctrl_constant0 = 32'h0000_00A5; ctrl_constant1 = 32'h0000_5A00;
    run_traffic(1, 0, 2, 4, 0, 0, 0, 1'b0);
    @(posedge aclk);
    #1;
    s1_axis_tvalid = 1'b1; s1_axis_tdata = rand_data(); s1_axis_tkeep = 64'hFFFF_FFFF_FFFF_FFFF;
    s1_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      if (s1_axis_tready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_grant: s1_tready=0, required 1 within 20 cycles");
    end
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    s1_axis_tvalid = 1'b0;
    #1;
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL reset_mid: m_tvalid=%0b const=%0h gv=%0b gid=%0b, required all 0",
               m_axis_tvalid, adder_constant, grant_valid, grant_id);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_ptr = 1'b0; model_cnt0 = 0; model_cnt1 = 0;
    run_traffic(2, 2, 1, 4, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      ctrl_constant0 = $urandom; ctrl_constant1 = $urandom;
      run_traffic($urandom_range(5, 1), $urandom_range(5, 0), 1, 6, 25, 40, 10, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_s1_first();
    test_backpressure();
    test_const_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
